spi_ctrl_sequencer: RTL and testbench
=====================================

# spi_ctrl_sequencer

Sequences multi-byte SPI transactions from the contents of the SPI control register. It watches the register's send bit and asserts the selected chip select. It fires the byte engine once per transfer, walks the TX/RX buffer addresses and writes received bytes into the RX buffer. On completion it returns the received count and the send-clear request to the control register. It sits between the SPI control register, the TX/RX buffers and the SPI byte engine.

## Interface
- `DATA_WIDTH`, 32, control-word width.
- `GAP_CYCLES`, 4, idle cycles between bytes (only with `SPI_CTRL_GAP_EN`); range 1..255.
- `clk_i`  in  1  system clock, rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `ctrl_i`  in  DATA_WIDTH  control-register value:
  - [0] send
  - [3:2] slave select
  - [12:4] n_tx_end (transfers minus 1)
- `busy_i`  in  1  byte engine busy.
- `done_i`  in  1  one-cycle pulse: byte finished, `rx_byte_i` valid.
- `rx_byte_i`  in  8  received byte.
- `start_o`  out  1  one-cycle pulse: engine loads the TX byte at `tx_addr_o` and starts.
- `tx_addr_o`  out  9  TX buffer read address.
- `rx_we_o`  out  1  RX buffer write strobe.
- `rx_addr_o`  out  9  RX buffer write address.
- `rx_data_o`  out  8  RX buffer write data.
- `cs_n_o`  out  4  chip selects, active low, at most one low.
- `wr_2_o`  out  1  one-cycle strobe: control register loads `n_rx_end_o`.
- `send_clear_o`  out  1  one-cycle strobe: control register clears send.
- `n_rx_end_o`  out  10  bytes received in the last transaction, 0..512.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CS_SETUP, START, WAIT, WRITE, GAP (macro only), FINISH, DRAIN.
- IDLE → CS_SETUP when `ctrl_i[0]`=1.
  - Latches n_tx_end and slave select.
  - Clears the byte index and the count.
- CS_SETUP (1 cycle):
  - `cs_n_o` = ~(1 << sel).
  - `tx_addr_o` = index.
  - Then → START.
- START (1 cycle):
  - `start_o` = 1, provided `busy_i` = 0.
  - Otherwise stays in START with `start_o` = 0.
  - Then → WAIT.
- WAIT:
  - On `done_i`, captures `rx_byte_i` → WRITE.
  - `done_i` is ignored in every other state.
- WRITE (1 cycle):
  - `rx_we_o` = 1, `rx_addr_o` = index, `rx_data_o` = captured byte.
  - Count increments.
  - If index = n_tx_end → FINISH.
  - Else index increments, then → GAP (macro) or START. `tx_addr_o` follows index.
- Abort: if `ctrl_i[0]` = 0 while in WAIT, the current byte completes and is written, then → FINISH regardless of index.
- FINISH (1 cycle):
  - `cs_n_o` = 4'b1111.
  - `wr_2_o` = 1, `send_clear_o` = 1, `n_rx_end_o` = count.
  - Then → DRAIN.
- DRAIN: stays until `ctrl_i[0]` = 0, then → IDLE. This prevents a stale send bit from retriggering.
- n_tx_end = 511 gives 512 transfers; count reaches 512 with no overflow.
  - Index is 9-bit and never wraps, because FINISH is taken at 511.
- `n_rx_end_o` holds its value until the next FINISH.

## Timing
- Reset values:
  - State IDLE.
  - `cs_n_o` = 4'b1111.
  - `start_o`, `rx_we_o`, `wr_2_o`, `send_clear_o`, `busy_o` = 0.
  - `tx_addr_o`, `rx_addr_o`, `rx_data_o`, `n_rx_end_o` = 0.
- Reset mid-transaction forces all of the above asynchronously; no FINISH strobes are emitted.
- All outputs are registered.
- Send seen at edge N:
  - `cs_n_o` low after N+1.
  - `start_o` high after N+2.
- `done_i` at edge M → `rx_we_o` high after M+1.
  - Next `start_o` after M+2 without the gap, M+2+GAP_CYCLES with it.
- Last `rx_we_o` at edge K → `wr_2_o`/`send_clear_o` after K+1.
- Same-cycle `done_i` and send falling: the byte is written, then FINISH.

## Configuration
- `SPI_CTRL_GAP_EN` defined:
  - GAP state inserted after every non-final WRITE.
  - Lasts `GAP_CYCLES` cycles; `cs_n_o` stays low.
- Undefined: GAP state and its counter are absent; WRITE goes directly to START.

## Test plan
- ctrl_i = 32'h0000_0001 (1 byte, slave 0); engine returns 8'hA5 → one `start_o`, `rx_we_o` with addr 0/data A5, `n_rx_end_o` = 1, `wr_2_o` and `send_clear_o` pulse together, `cs_n_o` back to 4'hF.
- n_tx_end = 3, sel = 2 → four `start_o` pulses at `tx_addr_o` 0..3, `cs_n_o` = 4'b1011 throughout, `n_rx_end_o` = 4.
- n_tx_end = 511 → 512 writes, last `rx_addr_o` = 511, `n_rx_end_o` = 512.
- n_tx_end = 7; clear send during byte 2 → bytes 0..2 written, `n_rx_end_o` = 3, FINISH strobes once.
- Hold send high after FINISH → no second transaction until send drops for ≥1 cycle; assert `rst_i` during WAIT → `cs_n_o` = 4'hF immediately, no `wr_2_o`.
- With `SPI_CTRL_GAP_EN`, GAP_CYCLES = 4 → exactly 6 cycles from `done_i` to the next `start_o`.

Source files
------------

// File: rtl/spi_ctrl_sequencer.sv
// spi_ctrl_sequencer: runs multi-byte SPI transactions from the control register through the byte engine and RX buffer.
// Define SPI_CTRL_GAP_EN to insert GAP_CYCLES idle cycles between bytes.
module spi_ctrl_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] ctrl_i,
  input  logic                  busy_i,
  input  logic                  done_i,
  input  logic [7:0]            rx_byte_i,
  output logic                  start_o,
  output logic [8:0]            tx_addr_o,
  output logic                  rx_we_o,
  output logic [8:0]            rx_addr_o,
  output logic [7:0]            rx_data_o,
  output logic [3:0]            cs_n_o,
  output logic                  wr_2_o,
  output logic                  send_clear_o,
  output logic [9:0]            n_rx_end_o,
  output logic                  busy_o
);
`ifdef SPI_CTRL_GAP_EN
  typedef enum logic [2:0] {IDLE, CS_SETUP, START, WAIT, WRITE, FINISH, DRAIN, GAP} state_t;
  logic [7:0] gap_q;
`else
  typedef enum logic [2:0] {IDLE, CS_SETUP, START, WAIT, WRITE, FINISH, DRAIN} state_t;
`endif
  state_t     state_q, state_d;
  logic [8:0] n_end_q, idx_q;
  logic [1:0] sel_q;
  logic [9:0] cnt_q;
  logic [7:0] rx_q;
  logic       abort_q;
  logic       last;
  assign last = (idx_q == n_end_q) || abort_q;
`ifndef SPI_CTRL_GAP_EN
  logic unused;
  assign unused = ^{ctrl_i[DATA_WIDTH-1:13], ctrl_i[1], GAP_CYCLES[0]};
`else
  logic unused;
  assign unused = ^{ctrl_i[DATA_WIDTH-1:13], ctrl_i[1]};
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = ctrl_i[0] ? CS_SETUP : IDLE;
      CS_SETUP: state_d = START;
      START:    state_d = busy_i ? START : WAIT;
      WAIT:     state_d = done_i ? WRITE : WAIT;
`ifdef SPI_CTRL_GAP_EN
      WRITE:    state_d = last ? FINISH : GAP;
      GAP:      state_d = (gap_q == 8'd0) ? START : GAP;
`else
      WRITE:    state_d = last ? FINISH : START;
`endif
      FINISH:   state_d = DRAIN;
      DRAIN:    state_d = ctrl_i[0] ? DRAIN : IDLE;
      default:  state_d = IDLE;
    endcase
  end
  // Outputs are registered from the current state, so each lags its state by one edge.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      start_o      <= 1'b0;
      tx_addr_o    <= '0;
      rx_we_o      <= 1'b0;
      rx_addr_o    <= '0;
      rx_data_o    <= '0;
      cs_n_o       <= 4'hF;
      wr_2_o       <= 1'b0;
      send_clear_o <= 1'b0;
      n_rx_end_o   <= '0;
      busy_o       <= 1'b0;
      n_end_q      <= '0;
      idx_q        <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      rx_q         <= '0;
      abort_q      <= 1'b0;
`ifdef SPI_CTRL_GAP_EN
      gap_q        <= '0;
`endif
    end else begin
      start_o      <= (state_q == START) && !busy_i;
      rx_we_o      <= state_q == WRITE;
      wr_2_o       <= state_q == FINISH;
      send_clear_o <= state_q == FINISH;
      busy_o       <= state_d != IDLE;
      tx_addr_o    <= idx_q;
      if (state_q == IDLE && ctrl_i[0]) begin
        n_end_q <= ctrl_i[12:4];
        sel_q   <= ctrl_i[3:2];
        idx_q   <= '0;
        cnt_q   <= '0;
        abort_q <= 1'b0;
      end
      if (state_q == CS_SETUP) cs_n_o <= ~(4'b0001 << sel_q);
      if (state_q == WAIT) begin
        if (!ctrl_i[0]) abort_q <= 1'b1;
        if (done_i) rx_q <= rx_byte_i;
      end
      if (state_q == WRITE) begin
        rx_addr_o <= idx_q;
        rx_data_o <= rx_q;
        cnt_q     <= cnt_q + 10'd1;
        if (!last) idx_q <= idx_q + 9'd1;
`ifdef SPI_CTRL_GAP_EN
        gap_q     <= 8'(GAP_CYCLES - 1);
`endif
      end
`ifdef SPI_CTRL_GAP_EN
      if (state_q == GAP) gap_q <= gap_q - 8'd1;
`endif
      if (state_q == FINISH) begin
        cs_n_o     <= 4'hF;
        n_rx_end_o <= cnt_q;
      end
    end
endmodule

// File: tb/tb_spi_ctrl_sequencer.sv
// tb_spi_ctrl_sequencer: directed bench for spi_ctrl_sequencer with a task-driven byte engine.
module tb_spi_ctrl_sequencer;
  localparam int GAP = 4;
`ifdef SPI_CTRL_GAP_EN
  localparam int EXP_LAT = 2 + GAP;
`else
  localparam int EXP_LAT = 2;
`endif
  logic        clk = 1'b0, rst_i = 1'b1;
  logic [31:0] ctrl_i = '0;
  logic        busy_i = 1'b0, done_i = 1'b0;
  logic [7:0]  rx_byte_i = '0;
  logic        start_o, rx_we_o, wr_2_o, send_clear_o, busy_o;
  logic [8:0]  tx_addr_o, rx_addr_o;
  logic [7:0]  rx_data_o;
  logic [3:0]  cs_n_o;
  logic [9:0]  n_rx_end_o;
  int n_cmp = 0, n_bad = 0;
  int n_start = 0, n_wr = 0, n_fin = 0, bad_tx = 0, bad_rx = 0, bad_cs = 0, bad_strobe = 0;
  logic [8:0] exp_tx = '0, exp_rx = '0, last_rx_addr = '0;
  logic [7:0] last_rx_data = '0;
  logic [3:0] exp_cs = 4'hE;

  spi_ctrl_sequencer #(.DATA_WIDTH(32), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .rst_i(rst_i), .ctrl_i(ctrl_i), .busy_i(busy_i), .done_i(done_i),
    .rx_byte_i(rx_byte_i), .start_o(start_o), .tx_addr_o(tx_addr_o), .rx_we_o(rx_we_o),
    .rx_addr_o(rx_addr_o), .rx_data_o(rx_data_o), .cs_n_o(cs_n_o), .wr_2_o(wr_2_o),
    .send_clear_o(send_clear_o), .n_rx_end_o(n_rx_end_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_i) begin
      exp_tx = '0;
      exp_rx = '0;
    end else begin
      if (start_o) begin
        n_start++;
        if (tx_addr_o !== exp_tx) bad_tx++;
        if (cs_n_o !== exp_cs) bad_cs++;
        exp_tx++;
      end
      if (rx_we_o) begin
        n_wr++;
        if (rx_addr_o !== exp_rx || rx_data_o !== (8'hA5 ^ rx_addr_o[7:0])) bad_rx++;
        last_rx_addr = rx_addr_o;
        last_rx_data = rx_data_o;
        exp_rx++;
      end
      if (wr_2_o !== send_clear_o) bad_strobe++;
      if (wr_2_o) begin
        n_fin++;
        exp_tx = '0;
        exp_rx = '0;
      end
    end

  task automatic serve_byte(input bit drop, output int lat);
    logic [7:0] b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!start_o && lat < 40);
    n_cmp++;
    if (start_o !== 1'b1) begin n_bad++; $display("FAIL start_wait: start_o=%b after %0d cycles, want 1", start_o, lat); end
    b = 8'hA5 ^ tx_addr_o[7:0];
    busy_i = 1'b1;
    if (drop) ctrl_i[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rx_byte_i = b;
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    busy_i = 1'b0;
    rx_byte_i = '0;
  endtask

  task automatic wait_finish(input logic [9:0] exp_n);
    int k = 0;
    while (!wr_2_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_cmp++; if (wr_2_o !== 1'b1) begin n_bad++; $display("FAIL finish_wait: wr_2_o=%b want 1", wr_2_o); end
    n_cmp++; if (send_clear_o !== 1'b1) begin n_bad++; $display("FAIL send_clear: got %b want 1", send_clear_o); end
    n_cmp++; if (n_rx_end_o !== exp_n) begin n_bad++; $display("FAIL n_rx_end: got %0d want %0d", n_rx_end_o, exp_n); end
    n_cmp++; if (cs_n_o !== 4'hF) begin n_bad++; $display("FAIL finish_cs_n: got %h want f", cs_n_o); end
    @(negedge clk);
    n_cmp++; if (wr_2_o !== 1'b0) begin n_bad++; $display("FAIL wr_2_pulse: got %b want 0", wr_2_o); end
    n_cmp++; if (n_rx_end_o !== exp_n) begin n_bad++; $display("FAIL n_rx_end_hold: got %0d want %0d", n_rx_end_o, exp_n); end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (cs_n_o !== 4'hF) begin n_bad++; $display("FAIL reset_cs_n: got %h want f", cs_n_o); end
    n_cmp++; if ({start_o, rx_we_o, wr_2_o, send_clear_o, busy_o} !== 5'b0) begin n_bad++; $display("FAIL reset_strobes: got %b want 00000", {start_o, rx_we_o, wr_2_o, send_clear_o, busy_o}); end
    n_cmp++; if ({tx_addr_o, rx_addr_o, rx_data_o, n_rx_end_o} !== 36'b0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {tx_addr_o, rx_addr_o, rx_data_o, n_rx_end_o}); end
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int lat, s0 = n_start, w0 = n_wr, f0 = n_fin;
    exp_cs = 4'hE;
    ctrl_i = 32'h0000_0001;
    @(negedge clk);
    n_cmp++; if (cs_n_o !== 4'hF) begin n_bad++; $display("FAIL single_cs_early: got %h want f", cs_n_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy_o); end
    @(negedge clk);
    n_cmp++; if (cs_n_o !== 4'hE) begin n_bad++; $display("FAIL single_cs_low: got %h want e", cs_n_o); end
    n_cmp++; if (start_o !== 1'b0) begin n_bad++; $display("FAIL single_start_early: got %b want 0", start_o); end
    serve_byte(1'b0, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL single_start_lat: got %0d want 1", lat); end
    wait_finish(10'd1);
    ctrl_i = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy: got %b want 0", busy_o); end
    n_cmp++; if (last_rx_data !== 8'hA5 || last_rx_addr !== 9'd0) begin n_bad++; $display("FAIL single_rx: got %h@%0d want a5@0", last_rx_data, last_rx_addr); end
    n_cmp++; if ({n_start - s0, n_wr - w0, n_fin - f0} !== {32'd1, 32'd1, 32'd1}) begin n_bad++; $display("FAIL single_counts: got %0d/%0d/%0d want 1/1/1", n_start - s0, n_wr - w0, n_fin - f0); end
  endtask

  task automatic test_multi();
    int lat, lat1 = 0, s0 = n_start, w0 = n_wr;
    exp_cs = 4'b1011;
    ctrl_i = 32'h0000_0039;
    for (int i = 0; i < 4; i++) begin
      serve_byte(1'b0, lat);
      if (i == 1) lat1 = lat;
    end
    n_cmp++; if (lat1 !== EXP_LAT) begin n_bad++; $display("FAIL multi_gap_lat: got %0d want %0d", lat1, EXP_LAT); end
    wait_finish(10'd4);
    ctrl_i = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({n_start - s0, n_wr - w0} !== {32'd4, 32'd4}) begin n_bad++; $display("FAIL multi_counts: got %0d/%0d want 4/4", n_start - s0, n_wr - w0); end
  endtask

  task automatic test_full();
    int lat, w0 = n_wr;
    exp_cs = 4'hE;
    ctrl_i = 32'h0000_1FF1;
    for (int i = 0; i < 512; i++) serve_byte(1'b0, lat);
    wait_finish(10'd512);
    ctrl_i = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (last_rx_addr !== 9'd511) begin n_bad++; $display("FAIL full_last_addr: got %0d want 511", last_rx_addr); end
    n_cmp++; if (n_wr - w0 !== 512) begin n_bad++; $display("FAIL full_writes: got %0d want 512", n_wr - w0); end
  endtask

  task automatic test_abort();
    int lat, s0 = n_start, w0 = n_wr, f0 = n_fin;
    exp_cs = 4'hE;
    ctrl_i = 32'h0000_0071;
    serve_byte(1'b0, lat);
    serve_byte(1'b0, lat);
    serve_byte(1'b1, lat);
    wait_finish(10'd3);
    repeat (20) @(negedge clk);
    n_cmp++; if ({n_start - s0, n_wr - w0, n_fin - f0} !== {32'd3, 32'd3, 32'd1}) begin n_bad++; $display("FAIL abort_counts: got %0d/%0d/%0d want 3/3/1", n_start - s0, n_wr - w0, n_fin - f0); end
    n_cmp++; if (last_rx_addr !== 9'd2) begin n_bad++; $display("FAIL abort_last_addr: got %0d want 2", last_rx_addr); end
  endtask

  task automatic test_drain();
    int lat, s0 = n_start, f0 = n_fin;
    exp_cs = 4'hE;
    ctrl_i = 32'h0000_0001;
    serve_byte(1'b0, lat);
    wait_finish(10'd1);
    repeat (20) @(negedge clk);
    n_cmp++; if (n_start - s0 !== 1) begin n_bad++; $display("FAIL drain_retrigger: got %0d starts want 1", n_start - s0); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL drain_busy: got %b want 1", busy_o); end
    ctrl_i = '0;
    @(negedge clk);
    ctrl_i = 32'h0000_0001;
    serve_byte(1'b0, lat);
    wait_finish(10'd1);
    ctrl_i = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({n_start - s0, n_fin - f0} !== {32'd2, 32'd2}) begin n_bad++; $display("FAIL drain_second: got %0d/%0d want 2/2", n_start - s0, n_fin - f0); end
  endtask

  task automatic test_rst_wait();
    int k = 0, w0 = n_wr, f0 = n_fin;
    exp_cs = 4'b1101;
    ctrl_i = 32'h0000_0005;
    while (!start_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_cmp++; if (start_o !== 1'b1) begin n_bad++; $display("FAIL rst_start_wait: got %b want 1", start_o); end
    n_cmp++; if (cs_n_o !== 4'b1101) begin n_bad++; $display("FAIL rst_cs_sel1: got %h want d", cs_n_o); end
    busy_i = 1'b1;
    @(negedge clk);
    #1 rst_i = 1'b1;
    #1;
    n_cmp++; if (cs_n_o !== 4'hF) begin n_bad++; $display("FAIL rst_async_cs: got %h want f", cs_n_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy: got %b want 0", busy_o); end
    ctrl_i = '0;
    busy_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if ({n_wr - w0, n_fin - f0} !== {32'd0, 32'd0}) begin n_bad++; $display("FAIL rst_no_finish: got %0d/%0d want 0/0", n_wr - w0, n_fin - f0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_full();
    test_abort();
    test_drain();
    test_rst_wait();
    n_cmp++; if ({bad_tx, bad_rx, bad_cs, bad_strobe} !== 128'b0) begin n_bad++; $display("FAIL monitor: tx=%0d rx=%0d cs=%0d strobe=%0d want all 0", bad_tx, bad_rx, bad_cs, bad_strobe); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
